// File: rtl/cpu_bus_seq_pkg.sv
// Shared types and constants for the 65c816 multi-byte bus sequencer and its address logic.
package cpu_bus_seq_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_DATA_W = 8;
    // Address bits below this index form the in-bank offset; bits at and above it are the bank.
    localparam int unsigned BANK_SPLIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Request/response and byte-wide memory bus signals of the sequencer.
// The slave modport is the sequencer's view; the master modport is the CPU/RAM side.
interface cpu_bus_seq_if #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BYTES = 3,
    parameter int unsigned CNT_W     = 2
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_we;
    logic [ADDR_W-1:0]             req_addr;
    logic [CNT_W-1:0]              req_len;
    logic                          req_wrap;
    logic [MAX_BYTES*DATA_W-1:0]   req_wdata;
    logic                          rsp_valid;
    logic                          rsp_err;
    logic [MAX_BYTES*DATA_W-1:0]   rsp_rdata;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_rdy;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wrap, req_wdata,
        input  mem_rdata, mem_rdy,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wrap, req_wdata,
        output mem_rdata, mem_rdy,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cpu_bus_seq_addr_inc.sv
// Combinational next-address for byte sequencing: full-width increment, or
// offset-only increment with the bank held (direct-page/stack wrap).
module cpu_bus_addr_inc
    import cpu_bus_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wrap,
    output logic [ADDR_W-1:0] next_addr
);

    logic [BANK_SPLIT-1:0] offset_inc;

    always_comb begin
        offset_inc = addr[BANK_SPLIT-1:0] + 1'b1;
        if (wrap) begin
            next_addr = {addr[ADDR_W-1:BANK_SPLIT], offset_inc};
        end else begin
            next_addr = addr + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_bus_seq.sv
// Multi-byte access sequencer: one request of 1..MAX_BYTES bytes becomes that many
// little-endian byte bus cycles. Define CPU_BUS_SEQ_TIMEOUT_EN for a per-byte wait timeout.
module cpu_bus_seq
    import cpu_bus_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BYTES = 3,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic         clk,
    input  logic         rst,
    cpu_bus_seq_if.slave bus
);

    if (MAX_BYTES >= (1 << CNT_W)) begin : g_cnt_w_chk
        $error("cpu_bus_seq: CNT_W too narrow for MAX_BYTES");
    end
    if (MAX_WAIT == 0) begin : g_wait_chk
        $error("cpu_bus_seq: MAX_WAIT must be at least 1");
    end

    seq_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            len_q, len_d;
    logic                        wrap_q, wrap_d;
    logic                        we_q, we_d;
    logic [MAX_BYTES*DATA_W-1:0] wdata_q, wdata_d;
    logic                        mem_en_q, mem_en_d;
    logic                        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        rsp_err_q, rsp_err_d;
    logic [MAX_BYTES*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_W-1:0]           addr_nxt;
    logic [CNT_W-1:0]            idx_nxt;
    logic [CNT_W-1:0]            last_idx;
    logic                        len_legal;

`ifdef CPU_BUS_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wait_expired;
    // Fires on the last of MAX_WAIT consecutive not-ready cycles.
    assign wait_expired = (32'(wait_q) == MAX_WAIT - 1);
`endif

    cpu_bus_addr_inc #(.ADDR_W(ADDR_W)) u_addr_inc (
        .addr      (mem_addr_q),
        .wrap      (wrap_q),
        .next_addr (addr_nxt)
    );

    assign idx_nxt   = idx_q + 1'b1;
    assign last_idx  = len_q - 1'b1;
    assign len_legal = (bus.req_len != '0) && (32'(bus.req_len) <= MAX_BYTES);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        wrap_d      = wrap_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (len_legal) begin
                        state_d     = ST_ACCESS;
                        idx_d       = '0;
                        len_d       = bus.req_len;
                        wrap_d      = bus.req_wrap;
                        we_d        = bus.req_we;
                        wdata_d     = bus.req_wdata;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = bus.req_addr;
                        mem_wdata_d = bus.req_wdata[DATA_W-1:0];
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
                        wait_d      = '0;
`endif
                    end else begin
                        state_d     = ST_DONE;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_rdy) begin
                    if (!we_q) begin
                        rsp_rdata_d[idx_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    end
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (idx_q == last_idx) begin
                        state_d     = ST_DONE;
                        mem_en_d    = 1'b0;
                        mem_we_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        idx_d       = idx_nxt;
                        mem_addr_d  = addr_nxt;
                        mem_wdata_d = wdata_q[idx_nxt*DATA_W +: DATA_W];
                    end
                end
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d     = ST_DONE;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                rsp_err_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            wrap_q      <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            wrap_q      <= wrap_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef CPU_BUS_SEQ_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
